// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared constants and types for the branch resolve unit:
//   DATA_W        - data/address bus width (64 bits)
//   INSTR_SIZE    - size of one instruction in bytes, used for fall-through PC
//   state_t       - resolve FSM encoding (RUN / FLUSH)
//   pred_entry_t  - one queued fetch-time prediction {pc, predicted next pc}
//   seq_next_pc() - fall-through PC adder (pc + INSTR_SIZE, wraps at 2^64)
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

   localparam int DATA_W = 64;

   localparam logic [DATA_W-1:0] INSTR_SIZE = 64'd4;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] next;
   } pred_entry_t;

   // Fall-through address; the carry out is dropped so the top of the address
   // space wraps to zero.
   function automatic logic [DATA_W-1:0] seq_next_pc(input logic [DATA_W-1:0] pc);
      return pc + INSTR_SIZE;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// -----------------------------------------------------------------------------
// pred_fifo
// Circular FIFO holding in-flight predictions, oldest entry at the head.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   push, din       - write din at the tail (ignored when full)
//   pop             - drop the head entry (ignored when empty)
//   clear           - empty the queue; wins over push and pop in the same cycle
//   dout            - head entry (combinational read)
//   count           - number of valid entries ($clog2(DEPTH)+1 bits)
//   full, empty     - occupancy flags derived from count
// -----------------------------------------------------------------------------
module pred_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 128
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full  = (count_r == DEPTH_C);
   assign empty = (count_r == {CW{1'b0}});
   assign count = count_r;
   assign dout  = mem_r[rd_ptr_r];

   // Qualify requests against occupancy so the pointers can never overrun.
   always_comb begin
      push_ok_s = push & ~full;
      pop_ok_s  = pop & ~empty;
   end

   // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (clear) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Back end of the gshare fetch predictor. Every fetch-time prediction for a
// control-flow instruction is queued and compared, in order, with the execute
// outcome. Each resolve trains the predictor; a wrong next-PC produces a fetch
// redirect, empties the queue and blocks traffic for FLUSH_CYCLES cycles.
// Ports:
//   clk, reset                        - clock, asynchronous active-high reset
//   pred_valid/pred_pc/pred_next      - fetch-side prediction push
//   pred_ready                        - queue accepts a push this cycle
//   res_valid/res_pc/res_taken/res_target - execute-side outcome of oldest entry
//   we/PCUpdate/targetUpdate/takenUpdate  - predictor training (1-cycle pulse)
//   redirect_valid/redirect_pc        - fetch redirect on mispredict (pulse)
//   busy_flush                        - unit is flushing after a redirect
//   branch_count/mispredict_count     - wrapping statistics
//   protocol_error                    - sticky; resolve with empty queue or PC mismatch
// -----------------------------------------------------------------------------
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pred_valid,
   input  logic [DATA_W-1:0] pred_pc,
   input  logic [DATA_W-1:0] pred_next,
   output logic              pred_ready,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_pc,
   input  logic              res_taken,
   input  logic [DATA_W-1:0] res_target,
   output logic              we,
   output logic [DATA_W-1:0] PCUpdate,
   output logic [DATA_W-1:0] targetUpdate,
   output logic              takenUpdate,
   output logic              redirect_valid,
   output logic [DATA_W-1:0] redirect_pc,
   output logic              busy_flush,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count,
   output logic              protocol_error
);

   localparam int QCW = $clog2(DEPTH) + 1;
   localparam int FCW = $clog2(FLUSH_CYCLES + 1);

   state_t            state_r;
   logic [FCW-1:0]    flush_cnt_r;

   pred_entry_t       push_entry_s;
   pred_entry_t       head_s;
   logic [QCW-1:0]    fifo_count_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;

   logic              ready_s;
   logic              push_s;
   logic              resolve_s;
   logic              pc_mismatch_s;
   logic              mispredict_s;
   logic              proto_evt_s;
   logic [DATA_W-1:0] seq_pc_s;
   logic [DATA_W-1:0] correct_pc_s;

   assign push_entry_s = '{pc: pred_pc, next: pred_next};
   assign pred_ready   = ready_s;
   assign busy_flush   = (state_r == ST_FLUSH);

   pred_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(pred_entry_t))
   ) u_pred_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (resolve_s),
      .clear (mispredict_s),
      .din   (push_entry_s),
      .dout  (head_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Resolve decode: compare the head prediction against the actual next PC.
   always_comb begin
      seq_pc_s = seq_next_pc(res_pc);
      if (res_taken) begin
         correct_pc_s = res_target;
      end else begin
         correct_pc_s = seq_pc_s;
      end
      // ready uses the registered occupancy, so a full queue refuses a push
      // even while the head is being popped.
      ready_s       = (state_r == ST_RUN) & ~fifo_full_s;
      resolve_s     = (state_r == ST_RUN) & res_valid & (fifo_count_s != {QCW{1'b0}});
      pc_mismatch_s = resolve_s & (res_pc != head_s.pc);
      // A PC mismatch means the queue is out of step with execute; treat it as
      // a mispredict so fetch restarts from a known-good PC.
      mispredict_s  = resolve_s & ((head_s.next != correct_pc_s) | pc_mismatch_s);
      proto_evt_s   = pc_mismatch_s | ((state_r == ST_RUN) & res_valid & fifo_empty_s);
      push_s        = pred_valid & ready_s & ~mispredict_s;
   end

   // RUN/FLUSH control with the flush-window down-counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_RUN;
         flush_cnt_r <= {FCW{1'b0}};
      end else begin
         case (state_r)
            ST_RUN: begin
               if (mispredict_s) begin
                  state_r     <= ST_FLUSH;
                  flush_cnt_r <= FCW'(FLUSH_CYCLES);
               end else begin
                  state_r     <= ST_RUN;
                  flush_cnt_r <= flush_cnt_r;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt_r <= FCW'(1)) begin
                  state_r     <= ST_RUN;
                  flush_cnt_r <= {FCW{1'b0}};
               end else begin
                  state_r     <= ST_FLUSH;
                  flush_cnt_r <= flush_cnt_r - FCW'(1);
               end
            end
            default: begin
               state_r     <= ST_RUN;
               flush_cnt_r <= {FCW{1'b0}};
            end
         endcase
      end
   end

   // Registered training, redirect and statistics outputs (one cycle after resolve).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we               <= 1'b0;
         PCUpdate         <= {DATA_W{1'b0}};
         targetUpdate     <= {DATA_W{1'b0}};
         takenUpdate      <= 1'b0;
         redirect_valid   <= 1'b0;
         redirect_pc      <= {DATA_W{1'b0}};
         branch_count     <= {CNT_W{1'b0}};
         mispredict_count <= {CNT_W{1'b0}};
         protocol_error   <= 1'b0;
      end else begin
         we             <= resolve_s;
         redirect_valid <= mispredict_s;
         protocol_error <= protocol_error | proto_evt_s;
         if (resolve_s) begin
            PCUpdate     <= res_pc;
            targetUpdate <= res_target;
            takenUpdate  <= res_taken;
            branch_count <= branch_count + CNT_W'(1);
         end else begin
            PCUpdate     <= PCUpdate;
            targetUpdate <= targetUpdate;
            takenUpdate  <= takenUpdate;
            branch_count <= branch_count;
         end
         if (mispredict_s) begin
            redirect_pc      <= correct_pc_s;
            mispredict_count <= mispredict_count + CNT_W'(1);
         end else begin
            redirect_pc      <= redirect_pc;
            mispredict_count <= mispredict_count;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed self-checking bench for branch_resolve_unit (DEPTH=4,
// FLUSH_CYCLES=2, CNT_W=32). Inputs change on the falling edge, outputs are
// sampled on the falling edge after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   logic        clk;
   logic        reset;
   logic        pred_valid;
   logic [63:0] pred_pc;
   logic [63:0] pred_next;
   logic        pred_ready;
   logic        res_valid;
   logic [63:0] res_pc;
   logic        res_taken;
   logic [63:0] res_target;
   logic        we;
   logic [63:0] PCUpdate;
   logic [63:0] targetUpdate;
   logic        takenUpdate;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        busy_flush;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;
   logic        protocol_error;

   int n_checks = 0;
   int n_fail   = 0;

   branch_resolve_unit #(
      .DEPTH        (4),
      .FLUSH_CYCLES (2),
      .CNT_W        (32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .pred_valid       (pred_valid),
      .pred_pc          (pred_pc),
      .pred_next        (pred_next),
      .pred_ready       (pred_ready),
      .res_valid        (res_valid),
      .res_pc           (res_pc),
      .res_taken        (res_taken),
      .res_target       (res_target),
      .we               (we),
      .PCUpdate         (PCUpdate),
      .targetUpdate     (targetUpdate),
      .takenUpdate      (takenUpdate),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .busy_flush       (busy_flush),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count),
      .protocol_error   (protocol_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      pred_valid = 1'b0;
      res_valid  = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      pred_valid = 1'b0;
      pred_pc    = 64'd0;
      pred_next  = 64'd0;
      res_valid  = 1'b0;
      res_pc     = 64'd0;
      res_taken  = 1'b0;
      res_target = 64'd0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_pred_ready", pred_ready, 64'd1);
      check("rst_we", we, 64'd0);
      check("rst_redirect_valid", redirect_valid, 64'd0);
      check("rst_busy_flush", busy_flush, 64'd0);
      check("rst_branch_count", branch_count, 64'd0);
      check("rst_mispredict_count", mispredict_count, 64'd0);
      check("rst_protocol_error", protocol_error, 64'd0);
      reset = 1'b0;
      step();

      // 1: correct not-taken prediction
      pred_valid = 1'b1; pred_pc = 64'h100; pred_next = 64'h104;
      step(); idle();
      check("t1_ready_after_push", pred_ready, 64'd1);
      res_valid = 1'b1; res_pc = 64'h100; res_taken = 1'b0; res_target = 64'h0;
      step(); idle();
      check("t1_we", we, 64'd1);
      check("t1_takenUpdate", takenUpdate, 64'd0);
      check("t1_PCUpdate", PCUpdate, 64'h100);
      check("t1_redirect_valid", redirect_valid, 64'd0);
      check("t1_branch_count", branch_count, 64'd1);
      check("t1_mispredict_count", mispredict_count, 64'd0);
      step();
      check("t1_we_pulse", we, 64'd0);

      // 2: taken mispredict, flush window ignores traffic
      pred_valid = 1'b1; pred_pc = 64'h200; pred_next = 64'h204;
      step(); idle();
      res_valid = 1'b1; res_pc = 64'h200; res_taken = 1'b1; res_target = 64'h80;
      step(); idle();
      check("t2_redirect_valid", redirect_valid, 64'd1);
      check("t2_redirect_pc", redirect_pc, 64'h80);
      check("t2_targetUpdate", targetUpdate, 64'h80);
      check("t2_takenUpdate", takenUpdate, 64'd1);
      check("t2_mispredict_count", mispredict_count, 64'd1);
      check("t2_branch_count", branch_count, 64'd2);
      check("t2_busy_flush", busy_flush, 64'd1);
      check("t2_ready_flush1", pred_ready, 64'd0);
      pred_valid = 1'b1; pred_pc = 64'h300; pred_next = 64'h304;
      res_valid  = 1'b1; res_pc  = 64'h999; res_taken = 1'b0;
      step(); idle();
      check("t2_ready_flush2", pred_ready, 64'd0);
      check("t2_busy_flush2", busy_flush, 64'd1);
      check("t2_redirect_pulse", redirect_valid, 64'd0);
      check("t2_we_in_flush", we, 64'd0);
      step();
      check("t2_ready_after_flush", pred_ready, 64'd1);
      check("t2_busy_after_flush", busy_flush, 64'd0);
      check("t2_no_error_in_flush", protocol_error, 64'd0);
      check("t2_we_after_flush", we, 64'd0);

      // 3: fill the queue, refuse a push into a full queue during a pop
      for (int i = 0; i < 4; i++) begin
         pred_valid = 1'b1;
         pred_pc    = 64'h400 + 64'(4 * i);
         pred_next  = 64'h404 + 64'(4 * i);
         step();
         if (i == 2) check("t3_ready_3_entries", pred_ready, 64'd1);
      end
      idle();
      check("t3_ready_full", pred_ready, 64'd0);
      pred_valid = 1'b1; pred_pc = 64'h410; pred_next = 64'h414;
      res_valid  = 1'b1; res_pc  = 64'h400; res_taken = 1'b0; res_target = 64'h0;
      step(); idle();
      check("t3_we_pop_full", we, 64'd1);
      check("t3_no_redirect", redirect_valid, 64'd0);
      check("t3_branch_count", branch_count, 64'd3);
      check("t3_ready_push_refused", pred_ready, 64'd1);
      pred_valid = 1'b1; pred_pc = 64'h410; pred_next = 64'h414;
      step(); idle();
      check("t3_ready_full_again", pred_ready, 64'd0);
      for (int i = 0; i < 4; i++) begin
         res_valid = 1'b1; res_pc = 64'h404 + 64'(4 * i); res_taken = 1'b0;
         step();
         check("t3_drain_no_redirect", redirect_valid, 64'd0);
         check("t3_drain_we", we, 64'd1);
      end
      idle();
      check("t3_drain_branch_count", branch_count, 64'd7);
      check("t3_drain_mispredict_count", mispredict_count, 64'd1);
      check("t3_drain_ready", pred_ready, 64'd1);

      // 5: fall-through PC wraps to zero
      pred_valid = 1'b1; pred_pc = 64'hFFFF_FFFF_FFFF_FFFC; pred_next = 64'h0;
      step(); idle();
      res_valid = 1'b1; res_pc = 64'hFFFF_FFFF_FFFF_FFFC; res_taken = 1'b0; res_target = 64'h0;
      step(); idle();
      check("t5_we", we, 64'd1);
      check("t5_PCUpdate", PCUpdate, 64'hFFFF_FFFF_FFFF_FFFC);
      check("t5_no_redirect", redirect_valid, 64'd0);
      check("t5_branch_count", branch_count, 64'd8);
      check("t5_mispredict_count", mispredict_count, 64'd1);
      check("t5_busy_flush", busy_flush, 64'd0);

      // 4a: PC mismatch with otherwise-correct next PC forces a redirect
      pred_valid = 1'b1; pred_pc = 64'h600; pred_next = 64'h614;
      step(); idle();
      res_valid = 1'b1; res_pc = 64'h610; res_taken = 1'b0;
      step(); idle();
      check("t4_mismatch_error", protocol_error, 64'd1);
      check("t4_mismatch_redirect", redirect_valid, 64'd1);
      check("t4_mismatch_redirect_pc", redirect_pc, 64'h614);
      check("t4_mismatch_PCUpdate", PCUpdate, 64'h610);
      check("t4_branch_count", branch_count, 64'd9);
      check("t4_mispredict_count", mispredict_count, 64'd2);

      // 6: asynchronous reset during FLUSH with pulses and counters live
      #2 reset = 1'b1;
      #1;
      check("t6_async_we", we, 64'd0);
      check("t6_async_redirect_valid", redirect_valid, 64'd0);
      check("t6_async_redirect_pc", redirect_pc, 64'd0);
      check("t6_async_busy_flush", busy_flush, 64'd0);
      check("t6_async_branch_count", branch_count, 64'd0);
      check("t6_async_mispredict_count", mispredict_count, 64'd0);
      check("t6_async_protocol_error", protocol_error, 64'd0);
      check("t6_async_PCUpdate", PCUpdate, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      check("t6_ready_after_reset", pred_ready, 64'd1);

      // 4b: resolve with an empty queue
      res_valid = 1'b1; res_pc = 64'h500; res_taken = 1'b0;
      step(); idle();
      check("t4_empty_error", protocol_error, 64'd1);
      check("t4_empty_no_we", we, 64'd0);
      check("t4_empty_no_redirect", redirect_valid, 64'd0);
      check("t4_empty_branch_count", branch_count, 64'd0);
      step();
      check("t4_error_sticky", protocol_error, 64'd1);

      // Push into an empty queue is not visible to a same-cycle resolve
      pred_valid = 1'b1; pred_pc = 64'h700; pred_next = 64'h704;
      res_valid  = 1'b1; res_pc  = 64'h700; res_taken = 1'b0;
      step(); idle();
      check("t7_same_cycle_no_we", we, 64'd0);
      check("t7_same_cycle_branch_count", branch_count, 64'd0);
      res_valid = 1'b1; res_pc = 64'h700; res_taken = 1'b0;
      step(); idle();
      check("t7_later_we", we, 64'd1);
      check("t7_later_branch_count", branch_count, 64'd1);
      check("t7_later_no_redirect", redirect_valid, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Back-end counterpart of the gshare fetch predictor.
- Queues every fetch-time prediction for a control-flow instruction (jal, jalr, branch) and compares each against the execute-stage outcome, in order.
- Drives the predictor training port (we, PCUpdate, targetUpdate, takenUpdate).
- On a mispredict, issues a fetch redirect and runs a fixed flush window; keeps branch and mispredict statistics.

Parameters:
- DEPTH, 4, in-flight prediction queue entries (power of 2, minimum 2)
- FLUSH_CYCLES, 2, cycles the unit refuses traffic after a redirect (minimum 1)
- CNT_W, 32, width of the statistics counters

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- pred_valid  in  1  fetch pushes a prediction this cycle
- pred_pc  in  `DataBusBits  PC of the predicted instruction
- pred_next  in  `DataBusBits  predicted next PC (predictor PCPrediction)
- pred_ready  out  1  queue can accept a push
- res_valid  in  1  execute resolves the oldest queued instruction
- res_pc  in  `DataBusBits  PC of the resolved instruction
- res_taken  in  1  actual direction (1 = taken; always 1 for jal/jalr)
- res_target  in  `DataBusBits  actual target when taken
- we  out  1  predictor update strobe
- PCUpdate  out  `DataBusBits  PC being trained
- targetUpdate  out  `DataBusBits  actual target
- takenUpdate  out  1  actual direction
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  `DataBusBits  correct next PC
- busy_flush  out  1  unit is in the FLUSH state
- branch_count  out  CNT_W  resolved instructions
- mispredict_count  out  CNT_W  mispredicts
- protocol_error  out  1  sticky flag for an illegal event

Behaviour:
- Reset values:
  - queue empty; state RUN
  - all outputs 0, except pred_ready = 1
- Queue: circular FIFO of {pred_pc, pred_next}, with read/write pointers and a count of log2(DEPTH)+1 bits.
- Push rule: a push occurs when pred_valid & pred_ready.
  - pred_ready = (state==RUN) & (count<DEPTH).
  - pred_ready is computed from the registered count, so a full queue does not accept a push even in a cycle with a pop.
- Resolve (state RUN, res_valid, count>0) pops the head entry. In that cycle:
  - correct_pc = res_taken ? res_target : res_pc+4, using 64-bit wrap-around addition.
  - mispredict = (head.pred_next != correct_pc).
  - If res_pc != head.pred_pc, set protocol_error. The resolve is still processed as a mispredict.
- Registered outputs, valid the cycle after the resolve (1-cycle latency):
  - we = 1, PCUpdate = res_pc, targetUpdate = res_target, takenUpdate = res_taken
  - branch_count increments by 1, wrapping.
- Mispredict, also on the next cycle:
  - redirect_valid = 1 and redirect_pc = correct_pc.
  - mispredict_count increments by 1, wrapping.
  - The queue is cleared: pointers and count go to 0. A push in the same cycle is discarded.
  - State goes to FLUSH and a down-counter loads FLUSH_CYCLES.
- FLUSH state:
  - pred_ready = 0 and busy_flush = 1.
  - pred_valid and res_valid are ignored; they do not set the error flag.
  - The counter decrements each cycle; when it reaches 1, state returns to RUN.
  - The first push is accepted exactly FLUSH_CYCLES+1 cycles after the mispredict resolve.
- res_valid in RUN with count==0: sets protocol_error; no update or redirect is produced.
- Pulse outputs: we and redirect_valid are single-cycle pulses; they deassert the next cycle unless another resolve occurs.
- Simultaneous push and correct-prediction resolve: both happen and count is unchanged. The entry pushed into an empty queue is not visible to a resolve in the same cycle.
- Reset asserted mid-operation: all state is cleared immediately, including in-flight redirects and counters. protocol_error clears only on reset.

Decomposition:
- Shared package / header diagv2_const.vh holds:
  - `DataBusBits
  - the state encoding (RUN=1'b0, FLUSH=1'b1)
  - the instruction-size constant 4
- One sub-module, pred_fifo: parameterised DEPTH × width FIFO with push, pop, clear, count, full and empty.
- The existing adder module computes res_pc+4.

Test Plan:
1. Push {0x100, 0x104}, then resolve res_pc=0x100, res_taken=0 -> next cycle we=1, takenUpdate=0, PCUpdate=0x100, redirect_valid=0, branch_count=1, mispredict_count=0.
2. Push {0x200, 0x204}, then resolve taken with target 0x80 -> redirect_valid=1, redirect_pc=0x80, mispredict_count=1, queue empty; pred_ready=0 for 2 cycles, then 1.
3. Push 4 entries back-to-back with DEPTH=4 -> pred_ready=0 after the 4th push; a 5th push with a simultaneous correct resolve is refused; the next cycle accepts it.
4. Resolve with the queue empty, and separately with res_pc≠head pred_pc -> protocol_error=1 and stays 1 until reset; the mismatch case also produces a redirect.
5. pred_next=0x0 with res_pc=0xFFFFFFFFFFFFFFFC, not taken -> correct_pc=0x0 by wrap-around, no mispredict.
6. Assert reset during FLUSH with counters nonzero -> outputs return to reset values immediately (asynchronously); pred_ready=1 after reset is released.
